tpu_tile_sequencer: RTL

//  Parametrised successor to the single-tile systolic control FSM. Sequences a full MxN (reduction K)

---
 rtl/tpu_pkg.sv | 29 ++
 rtl/tpu_tile_sequencer_if.sv | 49 ++++
 rtl/tpu_tile_iter.sv | 109 ++++++++++
 rtl/tpu_tile_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU tile sequencer: FSM state encoding,
// tile traversal order and a ceiling-division helper for tile counts.
package tpu_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_CMP_REQ,
        S_CMP_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_NEXT,
        S_DONE
    } state_e;

    typedef enum logic {
        ORDER_TN_INNER,
        ORDER_TM_INNER
    } tile_order_e;

    // Output tiles walk along a row of N tiles before stepping down to the next M row.
    localparam tile_order_e TILE_ORDER = ORDER_TN_INNER;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/tpu_tile_sequencer_if.sv
// Bundle of host, queue/engine handshake and address signals around the
// tile sequencer. The master side is the sequencer; the slave side is the
// host plus the queue_array / systolic / write_back engines.
interface tpu_tile_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DIM_W  = 8
);
    logic              tpu_start;
    logic              tpu_abort;
    logic [DIM_W-1:0]  dim_m;
    logic [DIM_W-1:0]  dim_n;
    logic [DIM_W-1:0]  dim_k;
    logic [ADDR_W-1:0] data_base;
    logic [ADDR_W-1:0] weight_base;
    logic [ADDR_W-1:0] out_base;
    logic              rempty;
    logic              wfull;
    logic              read_done;
    logic              compute_done;
    logic              write_done;
    logic              read_start;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_w_addr;
    logic [DIM_W-1:0]  rd_size;
    logic              compute_start;
    logic              write_start;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy;
    logic              tpu_done;
    logic              err;

    modport master (
        input  tpu_start, tpu_abort, dim_m, dim_n, dim_k,
        input  data_base, weight_base, out_base,
        input  rempty, wfull, read_done, compute_done, write_done,
        output read_start, rd_addr, rd_w_addr, rd_size,
        output compute_start, write_start, wr_addr,
        output busy, tpu_done, err
    );

    modport slave (
        output tpu_start, tpu_abort, dim_m, dim_n, dim_k,
        output data_base, weight_base, out_base,
        output rempty, wfull, read_done, compute_done, write_done,
        input  read_start, rd_addr, rd_w_addr, rd_size,
        input  compute_start, write_start, wr_addr,
        input  busy, tpu_done, err
    );
endinterface

// File: rtl/tpu_tile_iter.sv
// Tile iterator: holds the job configuration latched at start, walks the
// (tm, tn) output-tile counters and derives per-tile buffer addresses.
// Address arithmetic is done wide and then truncated, so addresses wrap
// silently modulo the buffer size.
module tpu_tile_iter
    import tpu_pkg::*;
#(
    parameter int ARRAY_SIZE = 4,
    parameter int ADDR_W     = 10,
    parameter int DIM_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [DIM_W-1:0]  dim_k,
    input  logic [ADDR_W-1:0] data_base,
    input  logic [ADDR_W-1:0] weight_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              last_tile,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] rd_w_addr,
    output logic [DIM_W-1:0]  rd_size,
    output logic [ADDR_W-1:0] wr_addr
);
    localparam int PROD_W = ADDR_W + DIM_W;

    logic [DIM_W-1:0]  tm_q, tm_d, tn_q, tn_d;
    logic [DIM_W-1:0]  tm_tiles_q, tm_tiles_d, tn_tiles_q, tn_tiles_d;
    logic [DIM_W-1:0]  k_q, k_d;
    logic [ADDR_W-1:0] data_base_q, data_base_d;
    logic [ADDR_W-1:0] weight_base_q, weight_base_d;
    logic [ADDR_W-1:0] out_base_q, out_base_d;
    logic              tm_at_end, tn_at_end;

    assign tm_at_end = (tm_q == tm_tiles_q - DIM_W'(1));
    assign tn_at_end = (tn_q == tn_tiles_q - DIM_W'(1));
    assign last_tile = tm_at_end && tn_at_end;

    // Latch a fresh configuration on start, otherwise step to the next tile on request.
    always_comb begin
        tm_d          = tm_q;
        tn_d          = tn_q;
        tm_tiles_d    = tm_tiles_q;
        tn_tiles_d    = tn_tiles_q;
        k_d           = k_q;
        data_base_d   = data_base_q;
        weight_base_d = weight_base_q;
        out_base_d    = out_base_q;
        if (load) begin
            tm_d          = '0;
            tn_d          = '0;
            tm_tiles_d    = DIM_W'(ceil_div(32'(dim_m), 32'(ARRAY_SIZE)));
            tn_tiles_d    = DIM_W'(ceil_div(32'(dim_n), 32'(ARRAY_SIZE)));
            k_d           = dim_k;
            data_base_d   = data_base;
            weight_base_d = weight_base;
            out_base_d    = out_base;
        end else if (advance) begin
            if (TILE_ORDER == ORDER_TN_INNER) begin
                if (tn_at_end) begin
                    tn_d = '0;
                    tm_d = tm_q + DIM_W'(1);
                end else begin
                    tn_d = tn_q + DIM_W'(1);
                end
            end else begin
                if (tm_at_end) begin
                    tm_d = '0;
                    tn_d = tn_q + DIM_W'(1);
                end else begin
                    tm_d = tm_q + DIM_W'(1);
                end
            end
        end
    end

    // Configuration and tile counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tm_q          <= '0;
            tn_q          <= '0;
            tm_tiles_q    <= '0;
            tn_tiles_q    <= '0;
            k_q           <= '0;
            data_base_q   <= '0;
            weight_base_q <= '0;
            out_base_q    <= '0;
        end else begin
            tm_q          <= tm_d;
            tn_q          <= tn_d;
            tm_tiles_q    <= tm_tiles_d;
            tn_tiles_q    <= tn_tiles_d;
            k_q           <= k_d;
            data_base_q   <= data_base_d;
            weight_base_q <= weight_base_d;
            out_base_q    <= out_base_d;
        end
    end

    assign rd_size   = k_q;
    assign rd_addr   = ADDR_W'(PROD_W'(data_base_q) + PROD_W'(tm_q) * PROD_W'(k_q));
    assign rd_w_addr = ADDR_W'(PROD_W'(weight_base_q) + PROD_W'(tn_q) * PROD_W'(k_q));
    assign wr_addr   = ADDR_W'(PROD_W'(out_base_q) + PROD_W'(tm_q) * PROD_W'(tn_tiles_q)
                               + PROD_W'(tn_q));

endmodule

// File: rtl/tpu_tile_sequencer.sv
// TPU tile sequencer: runs an MxN (reduction K) matmul as a series of
// ARRAY_SIZE x ARRAY_SIZE output tiles, each going read -> compute -> write-back.
// Optional build macro TPU_PERF_CNT_EN adds busy-cycle and stall-cycle counters.
module tpu_tile_sequencer
    import tpu_pkg::*;
#(
    parameter int ARRAY_SIZE = 4,
    parameter int ADDR_W     = 10,
    parameter int DIM_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tpu_tile_sequencer_if.master bus
`ifdef TPU_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_stalls
`endif
);
    state_e state_q, state_d;
    logic   err_q, err_d;
    logic   load, advance, last_tile, dims_ok, busy;
    logic   read_start, compute_start, write_start, tpu_done;

    assign dims_ok = (bus.dim_m != '0) && (bus.dim_n != '0) && (bus.dim_k != '0);
    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);

    tpu_tile_iter #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .ADDR_W     (ADDR_W),
        .DIM_W      (DIM_W)
    ) u_iter (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .advance     (advance),
        .dim_m       (bus.dim_m),
        .dim_n       (bus.dim_n),
        .dim_k       (bus.dim_k),
        .data_base   (bus.data_base),
        .weight_base (bus.weight_base),
        .out_base    (bus.out_base),
        .last_tile   (last_tile),
        .rd_addr     (bus.rd_addr),
        .rd_w_addr   (bus.rd_w_addr),
        .rd_size     (bus.rd_size),
        .wr_addr     (bus.wr_addr)
    );

    // Next-state and pulse generation; abort overrides everything outside IDLE.
    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        load          = 1'b0;
        advance       = 1'b0;
        read_start    = 1'b0;
        compute_start = 1'b0;
        write_start   = 1'b0;
        tpu_done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.tpu_start) begin
                    if (dims_ok) begin
                        load    = 1'b1;
                        err_d   = 1'b0;
                        state_d = S_RD_REQ;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_RD_REQ: begin
                if (!bus.wfull) begin
                    read_start = 1'b1;
                    state_d    = S_RD_WAIT;
                end
            end
            S_RD_WAIT:  if (bus.read_done) state_d = S_CMP_REQ;
            S_CMP_REQ: begin
                if (!bus.rempty) begin
                    compute_start = 1'b1;
                    state_d       = S_CMP_WAIT;
                end
            end
            S_CMP_WAIT: if (bus.compute_done) state_d = S_WR_REQ;
            S_WR_REQ: begin
                write_start = 1'b1;
                state_d     = S_WR_WAIT;
            end
            S_WR_WAIT:  if (bus.write_done) state_d = S_NEXT;
            S_NEXT: begin
                advance = 1'b1;
                state_d = last_tile ? S_DONE : S_RD_REQ;
            end
            S_DONE: begin
                tpu_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_q != S_IDLE) && bus.tpu_abort) begin
            state_d       = S_IDLE;
            advance       = 1'b0;
            read_start    = 1'b0;
            compute_start = 1'b0;
            write_start   = 1'b0;
            tpu_done      = 1'b0;
        end
    end

    // State and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign bus.read_start    = read_start;
    assign bus.compute_start = compute_start;
    assign bus.write_start   = write_start;
    assign bus.tpu_done      = tpu_done;
    assign bus.busy          = busy;
    assign bus.err           = err_q;

`ifdef TPU_PERF_CNT_EN
    logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;
    logic        stall;

    assign stall = ((state_q == S_RD_REQ) && bus.wfull) || ((state_q == S_CMP_REQ) && bus.rempty);

    // Saturating job counters, cleared when a new job is accepted.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (load) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else begin
            if (busy && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 32'd1;
            if (stall && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule
